// File: rtl/obf_pkg.sv
// Shared mode encodings, sequencer states and key-length helper for the obfuscation key bank.
package obf_pkg;

  localparam logic [1:0] OBF_PASS = 2'b00;
  localparam logic [1:0] OBF_INV  = 2'b01;
  localparam logic [1:0] OBF_ONE  = 2'b10;
  localparam logic [1:0] OBF_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_COMMIT,
    ST_ERR
  } obf_state_e;

  // Serial frame length: two mode bits per channel plus the optional parity bit.
  function automatic int obf_key_len(input int n_ch, input int parity_en);
    return 2 * n_ch + parity_en;
  endfunction

endpackage

// File: rtl/obf_cell.sv
// One obfuscated net: pass/invert/force-1/force-0 selected by a 2-bit mode, held at 0 while unarmed.
// Purely combinational, no handshake.
module obf_cell
  import obf_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       armed,
  input  logic       din,
  output logic       dout
);

  always_comb begin
    dout = 1'b0;
    if (armed) begin
      case (mode)
        OBF_PASS: dout = din;
        OBF_INV:  dout = ~din;
        OBF_ONE:  dout = 1'b1;
        OBF_ZERO: dout = 1'b0;
        default:  dout = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/obf_key_bank.sv
// Serial key loader (shadow, parity check, atomic commit) driving a bank of obf_cell channels.
// sig_out latency 1 when REG_OUT=1, else combinational; key_ready drops while pending or in error.
module obf_key_bank
  import obf_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int PARITY_EN = 1,
  parameter int REG_OUT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic            key_bit,
  input  logic            key_last,
  output logic            key_ready,
  input  logic            commit,
  input  logic            zeroize,
  input  logic [N_CH-1:0] sig_in,
  output logic [N_CH-1:0] sig_out,
  output logic            armed,
  output logic            key_err,
  output logic            pending
);

  localparam int KEY_LEN = obf_key_len(N_CH, PARITY_EN);
  localparam int CW      = $clog2(KEY_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(KEY_LEN - 1);

  obf_state_e          state, state_d;
  logic [CW-1:0]       cnt;
  logic [KEY_LEN-1:0]  shadow, shadow_d;
  logic [2*N_CH-1:0]   active;
  logic                accept, last_slot, parity_ok, enter_err;
  logic [N_CH-1:0]     cell_out;

  always_comb begin
    key_ready = 1'b0;
    pending   = 1'b0;
    key_err   = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: key_ready = 1'b1;
      ST_WAIT_COMMIT:   pending   = 1'b1;
      ST_ERR:           key_err   = 1'b1;
      default:          key_ready = 1'b0;
    endcase

    accept   = key_valid && key_ready;
    shadow_d = shadow;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (accept && (cnt == CW'(i))) shadow_d[i] = key_bit;
    end
    last_slot = (cnt == LAST_IDX);
    // The final bit is folded in via shadow_d, so parity covers the whole frame.
    parity_ok = (PARITY_EN == 0) || !(^shadow_d);

    state_d = state;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (last_slot)     state_d = (key_last && parity_ok) ? ST_WAIT_COMMIT : ST_ERR;
          else if (key_last) state_d = ST_ERR;
          else               state_d = ST_LOAD;
        end
      end
      ST_WAIT_COMMIT: if (commit) state_d = ST_IDLE;
      ST_ERR:         state_d = ST_ERR;
      default:        state_d = ST_IDLE;
    endcase
    if (zeroize) state_d = ST_IDLE;

    enter_err = (state_d == ST_ERR) && (state != ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shadow <= '0;
      active <= '0;
      armed  <= 1'b0;
    end else begin
      state <= state_d;
      if (zeroize || enter_err) begin
        cnt    <= '0;
        shadow <= '0;
        active <= '0;
        armed  <= 1'b0;
      end else begin
        if (accept) begin
          shadow <= shadow_d;
          cnt    <= cnt + CW'(1);
        end
        if ((state == ST_WAIT_COMMIT) && commit) begin
          active <= shadow[2*N_CH-1:0];
          armed  <= 1'b1;
          cnt    <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cell
    obf_cell u_cell (
      .mode  (active[2*g+1:2*g]),
      .armed (armed),
      .din   (sig_in[g]),
      .dout  (cell_out[g])
    );
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [N_CH-1:0] sig_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_q <= '0;
      else     sig_q <= cell_out;
    end
    assign sig_out = sig_q;
  end else begin : g_comb_out
    assign sig_out = cell_out;
  end

endmodule

// File: tb/tb_obf_key_bank.sv
// Directed + randomized bench for obf_key_bank (N_CH=4, parity on, registered output) against a frame-level model.
module tb_obf_key_bank;

  localparam int N_CH      = 4;
  localparam int PARITY_EN = 1;
  localparam int REG_OUT   = 1;
  localparam int KEY_LEN   = 2 * N_CH + PARITY_EN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            key_valid = 1'b0, key_bit = 1'b0, key_last = 1'b0;
  logic            commit = 1'b0, zeroize = 1'b0;
  logic [N_CH-1:0] sig_in = '0;
  logic            key_ready, armed, key_err, pending;
  logic [N_CH-1:0] sig_out;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: received bits as a list, plus the committed key and flags.
  int              m_frame[$];
  logic [7:0]      m_act;
  logic            m_armed, m_pend, m_err;
  logic [N_CH-1:0] m_sig;

  always #5 clk = ~clk;

  obf_key_bank #(.N_CH(N_CH), .PARITY_EN(PARITY_EN), .REG_OUT(REG_OUT)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_bit(key_bit), .key_last(key_last),
    .key_ready(key_ready), .commit(commit), .zeroize(zeroize), .sig_in(sig_in),
    .sig_out(sig_out), .armed(armed), .key_err(key_err), .pending(pending)
  );

  function automatic logic [N_CH-1:0] model_out(input logic [7:0] act, input logic arm,
                                                 input logic [N_CH-1:0] si);
    logic [N_CH-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      int m;
      m = (int'(act) >> (2 * i)) % 4;
      if (!arm)        r[i] = 1'b0;
      else if (m == 0) r[i] = si[i];
      else if (m == 1) r[i] = ~si[i];
      else if (m == 2) r[i] = 1'b1;
      else             r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_frame.delete();
    m_act = '0; m_armed = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_sig = '0;
  endtask

  task automatic model_fault();
    m_frame.delete();
    m_err = 1'b1; m_act = '0; m_armed = 1'b0;
  endtask

  task automatic model_edge(input logic v, b, l, c, z, input logic [N_CH-1:0] si);
    int ones;
    m_sig = model_out(m_act, m_armed, si);
    if (z) begin
      m_frame.delete();
      m_act = '0; m_armed = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    end else if (m_err) begin
      // locked until zeroize
    end else if (m_pend) begin
      if (c) begin
        for (int k = 0; k < 2 * N_CH; k++) m_act[k] = m_frame[k][0];
        m_armed = 1'b1; m_pend = 1'b0;
        m_frame.delete();
      end
    end else if (v) begin
      m_frame.push_back(int'(b));
      if (m_frame.size() == KEY_LEN) begin
        ones = 0;
        foreach (m_frame[k]) ones += m_frame[k];
        if (l && (ones % 2 == 0)) m_pend = 1'b1;
        else                      model_fault();
      end else if (l) begin
        model_fault();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ready"},   8'(key_ready), 8'(!m_pend && !m_err));
    chk({tag, "_pending"}, 8'(pending),   8'(m_pend));
    chk({tag, "_err"},     8'(key_err),   8'(m_err));
    chk({tag, "_armed"},   8'(armed),     8'(m_armed));
    chk({tag, "_sig"},     8'(sig_out),   8'(m_sig));
  endtask

  task automatic step(input string tag, input logic v, b, l, c, z, input logic [N_CH-1:0] si);
    key_valid = v; key_bit = b; key_last = l; commit = c; zeroize = z; sig_in = si;
    @(posedge clk);
    model_edge(v, b, l, c, z, si);
    #1;
    check_all(tag);
    key_valid = 1'b0; key_last = 1'b0; commit = 1'b0; zeroize = 1'b0;
  endtask

  task automatic send_key(input string tag, input logic [8:0] frame, input int nbits, input int last_idx);
    for (int k = 0; k < nbits; k++)
      step(tag, 1'b1, frame[k], k == last_idx, 1'b0, 1'b0, N_CH'($urandom));
  endtask

  task automatic zero(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, N_CH'($urandom));
  endtask

  initial begin
    logic [8:0] fr;
    logic [7:0] pay;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic load/commit of 8'hE4 (even parity -> parity bit 0).
    send_key("load_e4", 9'h0E4, 9, 8);
    chk("load_e4_pending_const", 8'(pending), 8'd1);
    step("commit_e4", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("commit_e4_armed_const", 8'(armed), 8'd1);
    step("e4_ones", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    chk("e4_ones_const", 8'(sig_out), 8'h05);
    step("e4_zeros", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("e4_zeros_const", 8'(sig_out), 8'h06);

    // Reload while armed: old key stays live until the new commit.
    send_key("reload", 9'h000, 9, 8);
    step("reload_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    chk("reload_hold_const", 8'(sig_out), 8'h05);
    step("reload_commit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
    step("reload_new", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    chk("reload_new_const", 8'(sig_out), 8'h0F);

    // Bad parity: tamper response clears the active key.
    send_key("badpar", 9'h1E4, 9, 8);
    step("badpar_idle", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111);
    chk("badpar_err_const", 8'(key_err), 8'd1);
    chk("badpar_sig_const", 8'(sig_out), 8'd0);
    chk("badpar_rdy_const", 8'(key_ready), 8'd0);
    zero("badpar_zero");
    chk("badpar_zero_err_const", 8'(key_err), 8'd0);
    chk("badpar_zero_rdy_const", 8'(key_ready), 8'd1);

    // Framing errors: early last, and missing last on the final bit.
    send_key("early_last", 9'h0E4, 5, 4);
    chk("early_last_err_const", 8'(key_err), 8'd1);
    zero("early_zero");
    send_key("no_last", 9'h0E4, 9, 99);
    chk("no_last_err_const", 8'(key_err), 8'd1);
    zero("no_last_zero");

    // Simultaneous commit+zeroize, commit in IDLE, key_valid while pending.
    send_key("sim_a", 9'h0E4, 9, 8);
    step("sim_a_commit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010);
    send_key("sim_b", 9'h000, 9, 8);
    step("sim_cz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
    chk("sim_cz_armed_const", 8'(armed), 8'd0);
    step("idle_commit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1010);
    send_key("wait_valid", 9'h0E4, 9, 8);
    for (int k = 0; k < 3; k++)
      step("wait_valid_ign", 1'b1, 1'b1, k == 2, 1'b0, 1'b0, N_CH'($urandom));
    step("wait_valid_commit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
    step("wait_valid_out", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
    chk("wait_valid_out_const", 8'(sig_out), 8'h05);

    // Asynchronous reset three bits into a frame, then a clean reload.
    send_key("mid", 9'h0FF, 3, 99);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    send_key("after_rst", 9'h0E4, 9, 8);
    step("after_rst_commit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    step("after_rst_out", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("after_rst_out_const", 8'(sig_out), 8'h06);

    // Randomized frames with gaps, occasional corruption and stray commits/zeroizes.
    for (int it = 0; it < 40; it++) begin
      pay = 8'($urandom);
      fr  = {^pay ^ ($urandom_range(0, 7) == 0), pay};
      for (int k = 0; k < KEY_LEN; k++) begin
        while ($urandom_range(0, 3) == 0)
          step("rnd_gap", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, N_CH'($urandom));
        step("rnd_bit", 1'b1, fr[k], k == KEY_LEN - 1, 1'b0, $urandom_range(0, 40) == 0, N_CH'($urandom));
      end
      for (int d = $urandom_range(0, 3); d > 0; d--)
        step("rnd_wait", 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, N_CH'($urandom));
      step("rnd_commit", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, N_CH'($urandom));
      for (int d = 0; d < 3; d++)
        step("rnd_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, N_CH'($urandom));
      if (m_err || $urandom_range(0, 9) == 0) zero("rnd_zero");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/obf_key_bank.md
Name: obf_key_bank

Overview:
- Parametrised bank of N_CH four-mode obfuscation cells. Each cell has four modes: pass, invert, force-1, force-0.
- The per-channel 2-bit mode selects are held in registers instead of being driven from primary inputs.
- The key is loaded serially through a valid/ready handshake into a shadow register, parity-checked, then committed atomically to the active register.
- The bank sits between a key-provisioning port and the obfuscated internal nets of a locked netlist.

Parameters:
- N_CH, 8: number of obfuscated channels; key payload is 2*N_CH bits.
- PARITY_EN, 1: when 1, one even-parity bit follows the payload. KEY_LEN = 2*N_CH + PARITY_EN.
- REG_OUT, 1: when 1, sig_out is registered (latency 1). When 0, sig_out is combinational from sig_in.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  serial key bit is valid.
- key_bit  in  1  serial key data, LSB first.
- key_last  in  1  marks the final bit of the key frame.
- key_ready  out  1  bank accepts a key bit; a bit is accepted when key_valid && key_ready.
- commit  in  1  pulse that copies shadow to active.
- zeroize  in  1  synchronous clear of all key state.
- sig_in  in  N_CH  nets to obfuscate.
- sig_out  out  N_CH  obfuscated nets.
- armed  out  1  active key is valid.
- key_err  out  1  sticky framing/parity error.
- pending  out  1  shadow key is complete and waiting for commit.

Behaviour:
- Modes per channel i, taken from active[2i+1:2i]:
  - 00 pass: out = in.
  - 01 invert: out = ~in.
  - 10 force-1: out = 1.
  - 11 force-0: out = 0.
- When armed=0, every channel outputs 0 (locked).
- Key bit ordering: the k-th accepted bit is written to shadow[k]. With PARITY_EN=1, the bit at index 2*N_CH is parity. Parity is good when the XOR of all KEY_LEN bits is 0.
- FSM states: IDLE, LOAD, WAIT_COMMIT, ERR. A bit counter cnt counts accepted bits.
  - IDLE:
    - key_ready=1.
    - An accepted bit stores shadow[0], sets cnt=1 and moves to LOAD.
    - If KEY_LEN==1 handling is needed it follows the LOAD rules; N_CH>=1 guarantees KEY_LEN>=2.
  - LOAD:
    - key_ready=1.
    - Each accepted bit stores shadow[cnt] and increments cnt.
    - key_last accepted with cnt != KEY_LEN-1 -> ERR.
    - Bit accepted at cnt == KEY_LEN-1 without key_last -> ERR.
    - Bit accepted at cnt == KEY_LEN-1 with key_last: if parity is good (or PARITY_EN=0) -> WAIT_COMMIT; otherwise -> ERR.
    - The transition takes effect on the clock after the final bit.
  - WAIT_COMMIT:
    - key_ready=0, pending=1.
    - On commit: active <= shadow payload, armed <= 1 on the next edge, -> IDLE.
  - ERR:
    - key_ready=0, key_err=1.
    - On entry: active cleared, armed <= 0 (tamper response), shadow cleared.
    - Exit only via zeroize or rst.
- commit outside WAIT_COMMIT is ignored.
- Reload while armed: IDLE and LOAD never disturb active or armed. The old key stays in effect until the next commit.
- zeroize, in any state: next edge clears shadow, active, cnt, armed and key_err, and sets state to IDLE.
  - zeroize has priority over commit and over a simultaneous accepted bit; that bit is dropped.
- key_valid is ignored while key_ready=0.
- Reset values: state=IDLE, cnt=0, shadow=0, active=0, armed=0, key_err=0, pending=0, sig_out=0 (REG_OUT=1), key_ready=1.
- Mid-load reset: all state is cleared asynchronously and the partial key is discarded.
- Output latency:
  - REG_OUT=1: sig_out(t+1) = f(active(t), armed(t), sig_in(t)).
  - REG_OUT=0: sig_out is combinational from the current register state.
  - After commit, the new mode is visible on sig_out at edge+1 for REG_OUT=0, and at edge+2 for REG_OUT=1.

Decomposition:
- Package obf_pkg holds:
  - Mode constants OBF_PASS=2'b00, OBF_INV=2'b01, OBF_ONE=2'b10, OBF_ZERO=2'b11.
  - FSM state enum.
  - Helper function for key length.
- Sub-module obf_cell: combinational 1-bit four-mode mux with an armed gate, instantiated N_CH times via generate.
- Sequencing (FSM, counter, shadow/active registers, parity) lives in obf_key_bank.

Test Plan:
- Basic load and commit. N_CH=4, PARITY_EN=1, REG_OUT=1. Send bits 0,0,1,0,0,1,1,1 then parity 0 (last). Expect pending=1. Pulse commit -> armed=1 and active=8'hE4. Then:
  - sig_in=4'b1111 -> sig_out=4'b0101.
  - sig_in=4'b0000 -> sig_out=4'b0110.
- Bad parity. Same payload with parity bit 1 -> key_err=1, armed=0, sig_out=0, key_ready=0. Then zeroize -> key_err=0, key_ready=1.
- Framing errors:
  - key_last on the 5th bit -> ERR.
  - 9th bit without key_last -> ERR.
- Reload while armed. Armed with 8'hE4; load 8'h00 (parity 0). While pending, sig_in=4'b1111 still gives 4'b0101. After commit, sig_in=4'b1111 gives 4'b1111.
- Simultaneous events:
  - commit and zeroize in the same cycle in WAIT_COMMIT -> armed=0, state IDLE.
  - commit in IDLE -> no change.
  - key_valid in WAIT_COMMIT -> ignored, shadow unchanged.
- Async reset asserted after 3 bits mid-load -> all outputs at reset values immediately. A full fresh 9-bit frame afterwards loads correctly.
